// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches into a DEPTH-entry circular buffer with redirect/flush.
// Optional misaligned-PC exception path enabled by FETCH_QUEUE_MISALIGN_CHECK_EN.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_read_enable,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_address,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_exception_valid,
  output logic [3:0]  out_exception_code
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [3:0]  code;
  } entry_t;

  typedef enum logic {RUN, HALT} state_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          inflight, inflight_exc;
  logic [31:0]   inflight_pc;
  logic [31:0]   fetch_pc;
  state_t        state;

  logic   room, issue, misalign, enq, deq, has_head;
  entry_t enq_entry, head;

`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  assign misalign         = (fetch_pc[1:0] != 2'b00);
  assign mem_read_address = fetch_pc;
`else
  assign misalign         = 1'b0;
  assign mem_read_address = {fetch_pc[31:2], 2'b00};
`endif

  assign room = ({1'b0, count} + (PW+2)'(inflight)) < (PW+2)'(DEPTH);
  // A pending exception entry blocks further issue so only one is produced.
  assign issue = reset && (state == RUN) && !redirect_valid && room &&
                 !(inflight && inflight_exc);
  assign mem_read_enable = issue && !misalign;

  assign enq = reset && !redirect_valid && inflight;
  assign enq_entry = inflight_exc ? '{pc: inflight_pc, inst: 32'h0, exc: 1'b1, code: 4'd0}
                                  : '{pc: inflight_pc, inst: mem_read_data, exc: 1'b0, code: 4'd0};

  assign head      = mem_q[rd_ptr];
  assign has_head  = reset && (count != '0);
  assign out_valid = has_head && !redirect_valid;
  assign deq       = out_valid && out_ready;

  assign out_pc              = has_head ? head.pc   : 32'h0;
  assign out_inst            = has_head ? head.inst : 32'h0;
  assign out_exception_valid = has_head ? head.exc  : 1'b0;
  assign out_exception_code  = has_head ? head.code : 4'd0;

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr] <= enq_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_exc <= 1'b0;
      inflight_pc  <= 32'h0;
      fetch_pc     <= RESET_PC;
      state        <= RUN;
    end else if (redirect_valid) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_exc <= 1'b0;
      fetch_pc     <= redirect_address;
      state        <= RUN;
    end else begin
      inflight     <= issue;
      inflight_exc <= issue && misalign;
      inflight_pc  <= mem_read_address;
      if (issue && !misalign) fetch_pc <= fetch_pc + 32'd4;
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(enq) - (PW+1)'(deq);
      if (enq && inflight_exc) state <= HALT;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0;
  logic        mem_read_enable;
  logic [31:0] mem_read_address, mem_read_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_address = 32'h0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_inst, out_pc;
  logic        out_exception_valid;
  logic [3:0]  out_exception_code;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
    .mem_read_data(mem_read_data),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .out_exception_valid(out_exception_valid), .out_exception_code(out_exception_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } ent_t;

  // Reference model: the queue contents, one optional outstanding fetch, next PC, halted flag.
  ent_t        q[$];
  bit          m_inf, m_inf_exc, m_halt;
  logic [31:0] m_inf_pc, m_pc;
  bit          e_issue, e_mis, e_en, e_valid;
  logic [31:0] e_addr;
  ent_t        e_head;
  logic [31:0] salt = 32'h0;
  int          checks = 0, failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ salt;
  endfunction

  task automatic model_reset();
    q.delete();
    m_inf = 0; m_inf_exc = 0; m_halt = 0;
    m_pc = RESET_PC; m_inf_pc = 32'h0;
  endtask

  // Called at a falling edge after inputs are set: computes the expected outputs.
  task automatic settle();
    #1;
    if (!reset) model_reset();
    e_addr  = MCHK ? m_pc : {m_pc[31:2], 2'b00};
    e_mis   = MCHK && (m_pc[1:0] != 2'b00);
    e_issue = reset && !m_halt && !redirect_valid &&
              (q.size() + int'(m_inf) < DEPTH) && !(m_inf && m_inf_exc);
    e_en    = e_issue && !e_mis;
    e_valid = reset && (q.size() != 0) && !redirect_valid;
    if (q.size() != 0) e_head = q[0];
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset) model_reset();
    else if (redirect_valid) begin
      q.delete();
      m_inf = 0; m_inf_exc = 0; m_halt = 0;
      m_pc = redirect_address;
    end else begin
      if (e_valid && out_ready) void'(q.pop_front());
      if (m_inf) begin
        if (m_inf_exc) begin
          q.push_back('{pc: m_inf_pc, inst: 32'h0, exc: 1'b1});
          m_halt = 1;
        end else q.push_back('{pc: m_inf_pc, inst: mem_word(m_inf_pc), exc: 1'b0});
      end
      m_inf = e_issue; m_inf_exc = e_issue && e_mis; m_inf_pc = e_addr;
      if (e_issue && !e_mis) m_pc = m_pc + 32'd4;
    end
    #1 mem_read_data = e_en ? mem_word(e_addr) : $urandom;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0; redirect_valid = 1'b0;
    settle(); advance();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({mem_read_enable, out_valid, out_exception_valid} !== 3'b000) begin
        failures++; $display("FAIL reset_ctrl en/valid/exc=%b%b%b want 000", mem_read_enable, out_valid, out_exception_valid);
      end
      checks++;
      if (mem_read_address !== RESET_PC) begin
        failures++; $display("FAIL reset_addr got %h want %h", mem_read_address, RESET_PC);
      end
      checks++;
      if ({out_inst, out_pc, out_exception_code} !== 68'h0) begin
        failures++; $display("FAIL reset_fields inst=%h pc=%h code=%h want 0", out_inst, out_pc, out_exception_code);
      end
      advance();
    end
  endtask

  task automatic test_stream();
    int first = -1;
    int nvalid = 0;
    logic [31:0] pcs[$];
    salt = 32'h0; out_ready = 1'b1; reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (c == 0) begin
        checks++;
        if (mem_read_enable !== 1'b1 || mem_read_address !== RESET_PC) begin
          failures++; $display("FAIL stream_first_req en=%b addr=%h want 1 %h", mem_read_enable, mem_read_address, RESET_PC);
        end
      end
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        nvalid++;
        pcs.push_back(out_pc);
        checks++;
        if (out_inst !== out_pc) begin
          failures++; $display("FAIL stream_inst got %h want %h", out_inst, out_pc);
        end
      end
      advance();
    end
    checks++;
    if (first != 2 || nvalid != 8) begin
      failures++; $display("FAIL stream_timing first=%0d count=%0d want 2 8", first, nvalid);
    end
    for (int k = 0; k < 4 && k < pcs.size(); k++) begin
      checks++;
      if (pcs[k] !== RESET_PC + 32'(4 * k)) begin
        failures++; $display("FAIL stream_pc[%0d] got %h want %h", k, pcs[k], RESET_PC + 32'(4 * k));
      end
    end
  endtask

  task automatic test_full();
    int nreq = 0;
    salt = 32'h5a5a_0000;
    out_ready = 1'b0; pulse_reset();
    for (int c = 0; c < 8; c++) begin
      settle();
      if (mem_read_enable === 1'b1) nreq++;
      advance();
    end
    settle();
    checks++;
    if (nreq != DEPTH || mem_read_enable !== 1'b0) begin
      failures++; $display("FAIL full_saturate reqs=%0d en=%b want %0d 0", nreq, mem_read_enable, DEPTH);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== RESET_PC + 32'(4 * c) || out_inst !== mem_word(RESET_PC + 32'(4 * c))) begin
        failures++; $display("FAIL full_drain[%0d] valid=%b pc=%h inst=%h want 1 %h", c, out_valid, out_pc, out_inst, RESET_PC + 32'(4 * c));
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    bit seen;
    out_ready = 1'b0; pulse_reset();
    for (int c = 0; c < 4; c++) begin settle(); advance(); end
    redirect_valid = 1'b1; redirect_address = 32'h100;
    settle();
    checks++;
    if (out_valid !== 1'b0 || mem_read_enable !== 1'b0) begin
      failures++; $display("FAIL redirect_cycle valid=%b en=%b want 0 0", out_valid, mem_read_enable);
    end
    advance();
    redirect_valid = 1'b0; out_ready = 1'b1;
    settle();
    checks++;
    if (mem_read_enable !== 1'b1 || mem_read_address !== 32'h100) begin
      failures++; $display("FAIL redirect_req en=%b addr=%h want 1 00000100", mem_read_enable, mem_read_address);
    end
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      settle();
      if (out_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (out_pc !== 32'h100) begin
          failures++; $display("FAIL redirect_first_pc got %h want 00000100", out_pc);
        end
      end
      advance();
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL redirect_timeout got no out_valid want one"); end
    // Two consecutive redirects: only the second target may be fetched.
    redirect_valid = 1'b1; redirect_address = 32'h300; settle(); advance();
    redirect_address = 32'h400; settle(); advance();
    redirect_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      settle();
      checks++;
      if (mem_read_enable !== e_en || mem_read_address !== e_addr || out_valid !== e_valid ||
          (e_valid && out_pc !== e_head.pc)) begin
        failures++; $display("FAIL b2b_redirect[%0d] en=%b addr=%h valid=%b pc=%h want %b %h %b %h",
                             c, mem_read_enable, mem_read_address, out_valid, out_pc, e_en, e_addr, e_valid, e_head.pc);
      end
      advance();
    end
  endtask

  task automatic test_misalign();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_address = 32'h102; settle(); advance();
    redirect_valid = 1'b0;
`ifdef FETCH_QUEUE_MISALIGN_CHECK_EN
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (mem_read_enable !== 1'b0) begin
        failures++; $display("FAIL misalign_noreq[%0d] en=%b want 0", c, mem_read_enable);
      end
      advance();
    end
    settle();
    checks++;
    if ({out_valid, out_exception_valid, out_exception_code, out_pc, out_inst} !== {1'b1, 1'b1, 4'd0, 32'h102, 32'h0}) begin
      failures++; $display("FAIL misalign_entry valid=%b exc=%b code=%h pc=%h inst=%h want 1 1 0 00000102 0",
                           out_valid, out_exception_valid, out_exception_code, out_pc, out_inst);
    end
    out_ready = 1'b1; advance();
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (out_valid !== 1'b0 || mem_read_enable !== 1'b0) begin
        failures++; $display("FAIL misalign_halt[%0d] valid=%b en=%b want 0 0", c, out_valid, mem_read_enable);
      end
      advance();
    end
    redirect_valid = 1'b1; redirect_address = 32'h200; settle(); advance();
    redirect_valid = 1'b0; settle();
    checks++;
    if (mem_read_enable !== 1'b1 || mem_read_address !== 32'h200) begin
      failures++; $display("FAIL misalign_resume en=%b addr=%h want 1 00000200", mem_read_enable, mem_read_address);
    end
    advance();
`else
    out_ready = 1'b1;
    settle();
    checks++;
    if (mem_read_enable !== 1'b1 || mem_read_address !== 32'h100) begin
      failures++; $display("FAIL nomis_addr en=%b addr=%h want 1 00000100", mem_read_enable, mem_read_address);
    end
    advance(); settle(); advance(); settle();
    checks++;
    if (out_valid !== 1'b1 || out_exception_valid !== 1'b0 || out_pc !== 32'h100) begin
      failures++; $display("FAIL nomis_entry valid=%b exc=%b pc=%h want 1 0 00000100", out_valid, out_exception_valid, out_pc);
    end
    advance();
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    out_ready = 1'b0; pulse_reset();
    for (int c = 0; c < 4; c++) begin settle(); advance(); end
    settle();
    checks++;
    if (out_valid !== 1'b1 || q.size() != 3) begin
      failures++; $display("FAIL rstmid_pre valid=%b want 1 (model entries %0d)", out_valid, q.size());
    end
    reset = 1'b0;
    settle();
    checks++;
    if (out_valid !== 1'b0 || mem_read_enable !== 1'b0) begin
      failures++; $display("FAIL rstmid_async valid=%b en=%b want 0 0", out_valid, mem_read_enable);
    end
    advance();
    reset = 1'b1; out_ready = 1'b1;
    settle();
    checks++;
    if (mem_read_enable !== 1'b1 || mem_read_address !== RESET_PC) begin
      failures++; $display("FAIL rstmid_restart en=%b addr=%h want 1 %h", mem_read_enable, mem_read_address, RESET_PC);
    end
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      if (c > 0) settle();
      if (out_valid === 1'b1) begin
        seen = 1;
        checks++;
        if (out_pc !== RESET_PC || c != 2) begin
          failures++; $display("FAIL rstmid_first pc=%h cycle=%0d want %h 2", out_pc, c, RESET_PC);
        end
      end
      advance();
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rstmid_timeout got no out_valid want one"); end
  endtask

  task automatic test_random();
    salt = $urandom;
    pulse_reset();
    for (int i = 0; i < 600; i++) begin
      out_ready        = ($urandom_range(0, 3) != 0);
      redirect_valid   = ($urandom_range(0, 11) == 0);
      redirect_address = $urandom;
      if ($urandom_range(0, 3) != 0) redirect_address[1:0] = 2'b00;
      reset = (i % 151 != 75);
      settle();
      checks++;
      if (mem_read_enable !== e_en || mem_read_address !== e_addr) begin
        failures++; $display("FAIL rand_req[%0d] en=%b addr=%h want %b %h", i, mem_read_enable, mem_read_address, e_en, e_addr);
      end
      checks++;
      if (out_valid !== e_valid) begin
        failures++; $display("FAIL rand_valid[%0d] got %b want %b", i, out_valid, e_valid);
      end
      if (e_valid) begin
        checks++;
        if ({out_pc, out_inst, out_exception_valid, out_exception_code} !== {e_head.pc, e_head.inst, e_head.exc, 4'd0}) begin
          failures++; $display("FAIL rand_head[%0d] pc=%h inst=%h exc=%b code=%h want %h %h %b 0",
                               i, out_pc, out_inst, out_exception_valid, out_exception_code, e_head.pc, e_head.inst, e_head.exc);
        end
      end
      advance();
    end
    reset = 1'b1; redirect_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_stream();
    test_full();
    test_redirect();
    test_misalign();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
